lcd_write_scheduler: RTL and testbench
======================================

Name: lcd_write_scheduler

Overview:
Buffers LCD command and data bytes from a requester and sequences them onto the bus-slave LCD peripheral at BASEADDRESS. The peripheral has no busy flag, so this block enforces the inter-write spacing itself.
After reset it runs the HD44780 power-up and init sequence, then drains its FIFO one byte per gap. It sits between the CPU/DMA side and the LCD peripheral's DATA_I/ADDR/WRSTB inputs.

Parameters:
BASEADDRESS, 32'h5000_0000, LCD peripheral base; +0 = command, +1 = data
FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2
PWRUP_CYCLES, 750_000, wait after reset before the first init command (15 ms at 50 MHz)
GAP_CYCLES, 100_010, WAIT cycles after a normal write; covers peripheral busy time
LONG_GAP_CYCLES, 160_000, WAIT cycles after command 0x01 or 0x02 (clear/home)

Ports:
ACLK  in  1  clock
RESETN  in  1  asynchronous active-low reset
IN_VALID  in  1  requester has a byte
IN_READY  out  1  FIFO can accept; = !full
IN_RS  in  1  0 = command, 1 = data
IN_BYTE  in  8  byte to send
REINIT  in  1  request re-run of init sequence
LCD_WRSTB  out  1  one-cycle write strobe to peripheral
LCD_ADDR  out  32  BASEADDRESS + rs
LCD_DATA_O  out  32  {24'b0, byte}
INIT_DONE  out  1  init sequence completed
BUSY  out  1  state != IDLE or FIFO not empty
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (RESETN low, async): state = PWRUP, counter = PWRUP_CYCLES-1, FIFO emptied. LCD_WRSTB=0, LCD_ADDR=BASEADDRESS, LCD_DATA_O=0, INIT_DONE=0, FIFO_LEVEL=0, IN_READY=1, BUSY=1.
- Reset mid-operation aborts everything and discards FIFO contents. A strobe in flight drops immediately.
- Counter width: $clog2 of the largest of the three cycle parameters, plus 1. All loads are value-1 and decrement to 0.
- FIFO push: IN_VALID && IN_READY at a clock edge stores {IN_RS, IN_BYTE}. Pushes are accepted in every state, including during init.
- When full, IN_READY=0 even if a pop occurs in the same cycle (no full bypass). Simultaneous push+pop when not full keeps the level unchanged.
- States:
  - PWRUP: decrement; at 0 -> INIT_ISSUE with init index 0.
  - INIT_ISSUE: one cycle; registers strobe for INIT_SEQ[idx] as a command (rs=0) -> INIT_WAIT.
  - INIT_WAIT: counter loaded with GAP_CYCLES-1, or LONG_GAP_CYCLES-1 if the byte is 0x01/0x02; decrement. At 0: if idx=last -> IDLE and INIT_DONE<=1, else idx+1 -> INIT_ISSUE.
  - IDLE, decision priority:
    1. REINIT=1: INIT_DONE<=0, idx=0 -> INIT_ISSUE; no PWRUP wait; FIFO retained.
    2. Else FIFO not empty: pop head, register strobe -> WAIT.
    3. Else stay.
  - WAIT: counter loaded as in INIT_WAIT (long gap only when rs=0 and byte is 0x01/0x02); decrement; at 0 -> IDLE.
- REINIT is sampled only in IDLE and ignored in all other states; it is level-sensitive.
- Strobe timing: outputs are registered. The decision cycle T is IDLE or INIT_ISSUE.
  - At T+1: LCD_WRSTB=1 for exactly one cycle, with LCD_ADDR/LCD_DATA_O valid.
  - LCD_ADDR/LCD_DATA_O hold their value until the next strobe.
- Latency: a push into an empty FIFO while IDLE at edge t gives LCD_WRSTB high in cycle t+2.
- Back-to-back spacing: strobe rising edges are exactly gap+2 cycles apart while the FIFO stays non-empty.
- Init writes and FIFO writes never interleave; FIFO drain starts only after INIT_DONE=1.

Decomposition:
- Package lcd_pkg holds:
  - state enum (PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE_WAIT naming per team style);
  - INIT_SEQ constant array {8'h38, 8'h0C, 8'h01, 8'h06} and INIT_LEN;
  - CMD_CLEAR=8'h01 and CMD_HOME=8'h02;
  - lcd_entry_t packed struct {rs, byte}.
- Sub-module lcd_cmd_fifo: synchronous FIFO of lcd_entry_t, FIFO_DEPTH entries, with full, empty and level outputs, on the same ACLK/RESETN.

Test Plan:
Bench parameters: PWRUP_CYCLES=20, GAP_CYCLES=8, LONG_GAP_CYCLES=16, FIFO_DEPTH=4.
- Reset release, no input -> first strobe at cycle 21: ADDR=5000_0000, DATA=0x38. Next strobes 0x0C (+10), 0x01 (+10), 0x06 (+18). INIT_DONE rises 9 cycles after the 0x06 strobe.
- After INIT_DONE, push data 'A' (rs=1, 0x41) -> strobe 2 cycles later with ADDR=5000_0001, DATA=0x0000_0041.
- Push 5 bytes back-to-back with IN_VALID held -> IN_READY=0 once FIFO_LEVEL=4. All 5 eventually strobed in order, spaced 10 cycles; no byte lost or duplicated.
- Push command 0x01 then data 0x42 -> strobes spaced 18 cycles. Push data 0x01 (rs=1) then 0x42 -> spaced 10 cycles.
- Assert REINIT in IDLE with 2 bytes queued -> INIT_DONE falls; 4 init strobes run; then the 2 queued bytes are sent. REINIT pulsed during WAIT -> ignored.
- Drop RESETN during WAIT with 3 bytes queued -> outputs return to reset values immediately, FIFO_LEVEL=0, and the PWRUP sequence restarts.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write scheduler.
// Holds the init sequence, command codes and FIFO entry layout.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        ISSUE_WAIT
    } lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    localparam int INIT_LEN = 4;
    localparam int IDX_W    = $clog2(INIT_LEN);

    // Element 0 is sent first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {
        8'h06, 8'h01, 8'h0C, 8'h38
    };

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and home are the slow HD44780 commands.
    function automatic logic is_long_cmd(lcd_entry_t e);
        return !e.rs && (e.data == CMD_CLEAR || e.data == CMD_HOME);
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Byte FIFO holding {rs, byte} entries waiting for the LCD.
// Head is presented combinationally; full never bypasses a pop.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          ACLK,
    input  logic          RESETN,
    input  logic          push,
    input  lcd_entry_t    wdata,
    input  logic          pop,
    output lcd_entry_t    rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    lcd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge ACLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge ACLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Sequences HD44780 init and queued bytes onto the LCD peripheral.
// Enforces inter-write spacing since the peripheral has no busy flag.
module lcd_write_scheduler
    import lcd_pkg::*;
#(
    parameter logic [31:0] BASEADDRESS     = 32'h5000_0000,
    parameter int          FIFO_DEPTH      = 16,
    parameter int          PWRUP_CYCLES    = 750_000,
    parameter int          GAP_CYCLES      = 100_010,
    parameter int          LONG_GAP_CYCLES = 160_000,
    localparam int         LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          ACLK,
    input  logic          RESETN,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          IN_RS,
    input  logic [7:0]    IN_BYTE,
    input  logic          REINIT,
    output logic          LCD_WRSTB,
    output logic [31:0]   LCD_ADDR,
    output logic [31:0]   LCD_DATA_O,
    output logic          INIT_DONE,
    output logic          BUSY,
    output logic [LW-1:0] FIFO_LEVEL
);

    localparam int MAXC = max3(PWRUP_CYCLES, GAP_CYCLES, LONG_GAP_CYCLES);
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] PWR_LD  = CW'(PWRUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LD = CW'(LONG_GAP_CYCLES - 1);

    lcd_state_t       state;
    lcd_state_t       state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic             init_done;
    logic             done_n;
    lcd_entry_t       cur;
    lcd_entry_t       cur_n;
    logic             wrstb;
    logic             wrstb_n;
    logic [CW-1:0]    gap_ld;

    lcd_entry_t       in_entry;
    lcd_entry_t       head;
    logic             pop;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;

    assign in_entry.rs   = IN_RS;
    assign in_entry.data = IN_BYTE;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ACLK   (ACLK),
        .RESETN (RESETN),
        .push   (IN_VALID),
        .wdata  (in_entry),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    // The byte just strobed decides how long the following wait is.
    assign gap_ld = is_long_cmd(cur) ? LONG_LD : GAP_LD;

    assign IN_READY   = !full;
    assign FIFO_LEVEL = level;
    assign LCD_WRSTB  = wrstb;
    assign LCD_ADDR   = BASEADDRESS + 32'(cur.rs);
    assign LCD_DATA_O = {24'b0, cur.data};
    assign INIT_DONE  = init_done;
    assign BUSY       = (state != IDLE) || !empty;

    // State, counter and registered strobe/address/data.
    always_ff @(posedge ACLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= PWRUP;
            cnt       <= PWR_LD;
            idx       <= '0;
            init_done <= 1'b0;
            cur       <= '0;
            wrstb     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            init_done <= done_n;
            cur       <= cur_n;
            wrstb     <= wrstb_n;
        end
    end

    // Next-state logic; a wait spends its strobe cycle loading the counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        done_n  = init_done;
        cur_n   = cur;
        wrstb_n = 1'b0;
        pop     = 1'b0;
        unique case (state)
            PWRUP: begin
                if (cnt == '0) begin
                    state_n = INIT_ISSUE;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            INIT_ISSUE: begin
                cur_n.rs   = 1'b0;
                cur_n.data = INIT_SEQ[idx];
                wrstb_n    = 1'b1;
                state_n    = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (wrstb) begin
                    cnt_n = gap_ld;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (idx == IDX_W'(INIT_LEN - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = INIT_ISSUE;
                end
            end
            IDLE: begin
                if (REINIT) begin
                    done_n  = 1'b0;
                    idx_n   = '0;
                    state_n = INIT_ISSUE;
                end else if (!empty) begin
                    pop     = 1'b1;
                    cur_n   = head;
                    wrstb_n = 1'b1;
                    state_n = ISSUE_WAIT;
                end
            end
            ISSUE_WAIT: begin
                if (wrstb) begin
                    cnt_n = gap_ld;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = PWRUP;
                cnt_n   = PWR_LD;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler with short timing parameters.
// Strobes are logged with cycle stamps and compared to hand-made tables.
module tb_lcd_write_scheduler;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam logic [31:0] BASE1 = 32'h5000_0001;

    logic        ACLK = 1'b0;
    logic        RESETN = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_RS = 1'b0;
    logic [7:0]  IN_BYTE = 8'h00;
    logic        REINIT = 1'b0;
    logic        IN_READY;
    logic        LCD_WRSTB;
    logic [31:0] LCD_ADDR;
    logic [31:0] LCD_DATA_O;
    logic        INIT_DONE;
    logic        BUSY;
    logic [2:0]  FIFO_LEVEL;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } strobe_t;

    typedef struct {
        int          grp;
        logic        rs;
        logic [7:0]  b;
        logic [31:0] addr;
        logic [31:0] data;
        int          space;
    } vec_t;

    strobe_t     slog[$];
    vec_t        vt [12];
    logic [31:0] ie_data [4] = '{32'h38, 32'h0C, 32'h01, 32'h06};
    int          ie_off  [4] = '{0, 10, 20, 38};

    lcd_write_scheduler #(
        .BASEADDRESS     (BASE),
        .FIFO_DEPTH      (4),
        .PWRUP_CYCLES    (20),
        .GAP_CYCLES      (8),
        .LONG_GAP_CYCLES (16)
    ) dut (
        .ACLK       (ACLK),
        .RESETN     (RESETN),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_RS      (IN_RS),
        .IN_BYTE    (IN_BYTE),
        .REINIT     (REINIT),
        .LCD_WRSTB  (LCD_WRSTB),
        .LCD_ADDR   (LCD_ADDR),
        .LCD_DATA_O (LCD_DATA_O),
        .INIT_DONE  (INIT_DONE),
        .BUSY       (BUSY),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) begin
        if (RESETN && LCD_WRSTB) begin
            slog.push_back('{cyc, LCD_ADDR, LCD_DATA_O});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit before summary");
        $fatal(1);
    end

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " wrstb"}, 32'(LCD_WRSTB), 0);
        chk({tag, " addr"}, LCD_ADDR, BASE);
        chk({tag, " data"}, LCD_DATA_O, 0);
        chk({tag, " init_done"}, 32'(INIT_DONE), 0);
        chk({tag, " level"}, 32'(FIFO_LEVEL), 0);
        chk({tag, " in_ready"}, 32'(IN_READY), 1);
        chk({tag, " busy"}, 32'(BUSY), 1);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && slog.size() < n; k++) tick();
        chk({tag, " strobe count"}, slog.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        for (k = 0; k < budget && BUSY !== 1'b0; k++) tick();
        chk({tag, " idle reached"}, 32'(BUSY), 0);
    endtask

    task automatic push(input logic rs, input logic [7:0] b, output int pc);
        int n;
        n = 0;
        IN_VALID = 1'b1;
        IN_RS = rs;
        IN_BYTE = b;
        while (IN_READY !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        pc = cyc;
        tick();
    endtask

    task automatic check_init(input int first, input string tag);
        wait_log(4, 120, tag);
        for (int i = 0; i < 4; i++) begin
            if (i < slog.size()) begin
                chk($sformatf("%s init%0d addr", tag, i), slog[i].addr, BASE);
                chk($sformatf("%s init%0d data", tag, i), slog[i].data,
                    ie_data[i]);
                chk($sformatf("%s init%0d cycle", tag, i),
                    slog[i].cyc - first, ie_off[i]);
            end
        end
        for (int n = 0; n < 100 && INIT_DONE !== 1'b1; n++) tick();
        chk({tag, " init_done cycle"}, cyc - first, 47);
    endtask

    initial begin
        int pc, first, cnt, k, prev, r, c;

        vt[0]  = '{0, 1'b1, 8'h41, BASE1, 32'h41, 2};
        vt[1]  = '{1, 1'b1, 8'h61, BASE1, 32'h61, 2};
        vt[2]  = '{1, 1'b1, 8'h62, BASE1, 32'h62, 10};
        vt[3]  = '{1, 1'b0, 8'h80, BASE,  32'h80, 10};
        vt[4]  = '{1, 1'b1, 8'h63, BASE1, 32'h63, 10};
        vt[5]  = '{1, 1'b1, 8'h64, BASE1, 32'h64, 10};
        vt[6]  = '{2, 1'b0, 8'h01, BASE,  32'h01, 2};
        vt[7]  = '{2, 1'b1, 8'h42, BASE1, 32'h42, 18};
        vt[8]  = '{3, 1'b1, 8'h01, BASE1, 32'h01, 2};
        vt[9]  = '{3, 1'b1, 8'h42, BASE1, 32'h42, 10};
        vt[10] = '{4, 1'b0, 8'h02, BASE,  32'h02, 2};
        vt[11] = '{4, 1'b1, 8'h43, BASE1, 32'h43, 18};

        #2 RESETN = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        RESETN = 1'b1;
        r = cyc;
        check_init(r + 21, "pwrup");

        for (int g = 0; g < 5; g++) begin
            slog.delete();
            first = -1;
            cnt = 0;
            for (int i = 0; i < 12; i++) begin
                if (vt[i].grp == g) begin
                    push(vt[i].rs, vt[i].b, pc);
                    if (first < 0) first = pc;
                    cnt++;
                end
            end
            IN_VALID = 1'b0;
            wait_idle(400, $sformatf("g%0d", g));
            chk($sformatf("g%0d count", g), slog.size(), cnt);
            k = 0;
            prev = first;
            for (int i = 0; i < 12; i++) begin
                if (vt[i].grp == g && k < slog.size()) begin
                    chk($sformatf("g%0d v%0d addr", g, i), slog[k].addr,
                        vt[i].addr);
                    chk($sformatf("g%0d v%0d data", g, i), slog[k].data,
                        vt[i].data);
                    chk($sformatf("g%0d v%0d spacing", g, i),
                        slog[k].cyc - prev, vt[i].space);
                    prev = slog[k].cyc;
                    k++;
                end
            end
        end

        slog.delete();
        c = cyc;
        REINIT = 1'b1;
        IN_VALID = 1'b1;
        IN_RS = 1'b1;
        IN_BYTE = 8'h71;
        tick();
        chk("reinit done fell", 32'(INIT_DONE), 0);
        REINIT = 1'b0;
        IN_BYTE = 8'h72;
        tick();
        IN_VALID = 1'b0;
        tick();
        chk("reinit queued level", 32'(FIFO_LEVEL), 2);
        check_init(c + 2, "reinit");
        wait_log(6, 60, "reinit drain");
        if (slog.size() >= 6) begin
            chk("reinit q0 addr", slog[4].addr, BASE1);
            chk("reinit q0 data", slog[4].data, 32'h71);
            chk("reinit q0 cycle", slog[4].cyc - c, 50);
            chk("reinit q1 data", slog[5].data, 32'h72);
            chk("reinit q1 cycle", slog[5].cyc - c, 60);
        end

        wait_idle(50, "pre-wait-reinit");
        slog.delete();
        push(1'b1, 8'h55, pc);
        IN_VALID = 1'b0;
        wait_log(1, 20, "wait-reinit");
        tick();
        REINIT = 1'b1;
        tick();
        REINIT = 1'b0;
        wait_idle(50, "wait-reinit");
        for (int i = 0; i < 5; i++) tick();
        chk("wait-reinit strobes", slog.size(), 1);
        chk("wait-reinit init_done", 32'(INIT_DONE), 1);

        slog.delete();
        push(1'b0, 8'h01, pc);
        IN_VALID = 1'b0;
        wait_log(1, 20, "clear");
        for (int i = 0; i < 4; i++) push(1'b1, 8'(8'h50 + i), pc);
        IN_VALID = 1'b0;
        chk("full level", 32'(FIFO_LEVEL), 4);
        chk("full in_ready", 32'(IN_READY), 0);
        IN_VALID = 1'b1;
        IN_BYTE = 8'h54;
        tick();
        tick();
        chk("full held level", 32'(FIFO_LEVEL), 4);
        IN_VALID = 1'b0;
        wait_log(2, 60, "pre-reset");
        chk("pre-reset wrstb", 32'(LCD_WRSTB), 1);
        chk("pre-reset level", 32'(FIFO_LEVEL), 3);
        chk("pre-reset data", LCD_DATA_O, 32'h50);
        RESETN = 1'b0;
        #1;
        chk_reset("mid reset");
        tick();
        tick();
        slog.delete();
        RESETN = 1'b1;
        r = cyc;
        check_init(r + 21, "restart");
        chk("restart level", 32'(FIFO_LEVEL), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
